// File: rtl/barrel_shift_arbiter.sv
// Purpose: two requesters share one rotate-right barrel shifter, round-robin arbitrated.
// Latency: 1 cycle from accept edge to out_valid; result held until out_ready.
// Backpressure: no accept while a result is held or in its handshake cycle.
// Optional: define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module barrel_shift_arbiter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             busy,
    output logic [CNTW-1:0]  txn_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_last_grant;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_id;
    logic [CNTW-1:0]    r_txn_cnt;

    logic               w_grant1;
    logic               w_accept;
    logic [WIDTH-1:0]   w_sel_data;
    logic [SHW-1:0]     w_sel_amt;
    logic [2*WIDTH-1:0] w_dbl;
    logic [WIDTH-1:0]   w_rot;

    // Arbitration: pick requester 1 when it is the only one, or on a tie when it is its turn.
    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        w_grant1 = req1_valid && !req0_valid;
`else
        w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
`endif
        w_accept   = !rst && (r_state == IDLE) && (req0_valid || req1_valid);
        req0_ready = w_accept && !w_grant1;
        req1_ready = w_accept && w_grant1;
    end

    // Rotate right: shifting a doubled copy brings wrapped bits into the low half.
    always_comb begin
        w_sel_data = w_grant1 ? req1_data : req0_data;
        w_sel_amt  = w_grant1 ? req1_amt  : req0_amt;
        w_dbl      = {w_sel_data, w_sel_data} >> w_sel_amt;
        w_rot      = w_dbl[WIDTH-1:0];
    end

    // Next-state: IDLE waits for an accept, HOLD waits for the consumer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next = HOLD;
            HOLD:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Capture the winner's result on accept; count completed output handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data   <= '0;
            r_out_id     <= 1'b0;
            r_last_grant <= 1'b1;
            r_txn_cnt    <= '0;
        end else if (w_accept) begin
            r_out_data   <= w_rot;
            r_out_id     <= w_grant1;
            r_last_grant <= w_grant1;
        end else if ((r_state == HOLD) && out_ready) begin
            r_txn_cnt    <= r_txn_cnt + 1'b1;
        end
    end

    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign txn_cnt   = r_txn_cnt;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Bench for barrel_shift_arbiter: directed scenarios followed by random traffic,
// each cycle checked against a transaction-level reference model.
module tb_barrel_shift_arbiter;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;
    localparam int CNTW  = 4;

    logic             clk;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic [SHW-1:0]   req0_amt, req1_amt;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_id;
    logic             busy;
    logic [CNTW-1:0]  txn_cnt;

    int n_vec;
    int n_err;

    // reference model state
    bit               m_hold;
    logic [WIDTH-1:0] m_data;
    bit               m_id;
    bit               m_last;
    int               m_cnt;

    barrel_shift_arbiter #(.WIDTH(WIDTH), .SHW(SHW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data(req0_data), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data(req1_data), .req1_amt(req1_amt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id),
        .busy(busy), .txn_cnt(txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] d, input int a);
        logic [WIDTH-1:0] r;
        for (int k = 0; k < WIDTH; k++) r[k] = d[(k + a) % WIDTH];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit rs,
                        input bit v0, input logic [7:0] d0, input logic [2:0] a0,
                        input bit v1, input logic [7:0] d1, input logic [2:0] a1,
                        input bit ordy);
        int g;
        @(negedge clk);
        rst = rs; out_ready = ordy;
        req0_valid = v0; req0_data = d0; req0_amt = a0;
        req1_valid = v1; req1_data = d1; req1_amt = a1;
        #1;
        g = -1;
        if (!rs && !m_hold) begin
            if (v0 && v1) begin
`ifdef ARB_FIXED_PRIO_EN
                g = 0;
`else
                g = m_last ? 0 : 1;
`endif
            end else if (v0) g = 0;
            else if (v1) g = 1;
        end
        chk("req0_ready", req0_ready, 32'(g == 0));
        chk("req1_ready", req1_ready, 32'(g == 1));
        chk("out_valid",  out_valid,  32'(m_hold));
        chk("busy",       busy,       32'(m_hold));
        chk("out_data",   out_data,   32'(m_data));
        chk("out_id",     out_id,     32'(m_id));
        chk("txn_cnt",    txn_cnt,    32'(m_cnt));
        if (rs) begin
            m_hold = 0; m_data = '0; m_id = 0; m_cnt = 0; m_last = 1;
        end else if (g >= 0) begin
            m_data = (g == 0) ? rot(d0, int'(a0)) : rot(d1, int'(a1));
            m_id   = (g == 1);
            m_last = (g == 1);
            m_hold = 1;
        end else if (m_hold && ordy) begin
            m_hold = 0;
            m_cnt  = (m_cnt + 1) % (1 << CNTW);
        end
    endtask

    // Check the registered result right after the next active edge against a fixed value.
    task automatic chk_after_edge(input string tag, input logic [7:0] exp);
        @(posedge clk);
        #1;
        chk(tag, out_data, 32'(exp));
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_hold = 0; m_data = '0; m_id = 0; m_last = 1; m_cnt = 0;
        rst = 1; out_ready = 0;
        req0_valid = 0; req0_data = '0; req0_amt = '0;
        req1_valid = 0; req1_data = '0; req1_amt = '0;

        // reset
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        step(1, 1, 8'hFF, 1, 1, 8'hFF, 1, 0);

        // basic rotate, with the known-answer value
        step(0, 1, 8'hB4, 3, 0, 8'h00, 0, 0);
        chk_after_edge("t1_rot_b4_3", 8'h96);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);

        // amount boundaries
        step(0, 1, 8'hA5, 0, 0, 8'h00, 0, 0);
        chk_after_edge("t2_rot_a5_0", 8'hA5);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1, 8'h01, 7, 0);
        chk_after_edge("t2_rot_01_7", 8'h02);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);

        // contention with consumer always ready
        for (int i = 0; i < 8; i++)
            step(0, 1, 8'(8'h11 * i), 3'(i), 1, 8'(8'h2F + i), 3'(7 - i), 1);

        // backpressure in HOLD
        step(0, 1, 8'hC3, 5, 1, 8'h3C, 2, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 8'h00, 1, 1, 8'hFF, 1, 0);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);

        // reset while holding, then contended request
        step(0, 0, 8'h00, 0, 1, 8'h5A, 4, 0);
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        step(0, 1, 8'h81, 1, 1, 8'h18, 1, 0);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);

        // counter wrap: 15 completions from reset, then one more
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 15; i++) begin
            step(0, 1, 8'(i), 3'(i), 0, 8'h00, 0, 0);
            step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        end
        step(0, 1, 8'h77, 2, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);

        // random traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(99) < 2,
                 1'($urandom), 8'($urandom), 3'($urandom),
                 1'($urandom), 8'($urandom), 3'($urandom),
                 $urandom_range(99) < 60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
